// File: rtl/packet_reader_if.sv
// Memory read port and output stream of the packet reader, bundled as one interface.
// master = the reader; slave = the memory model plus the stream sink.
interface packet_reader_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned PORT_WIDTH = 32
) ();

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [PORT_WIDTH-1:0] rd_data;

  logic [PORT_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/packet_reader.sv
// Reads len words from a one-cycle-latency memory at addresses 0..len-1 and streams them out
// through a registered 2-entry buffer, with m_last on the final word and a done pulse.
module packet_reader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned PORT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  packet_reader_if.master       bus
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  done_q, done_d;

  // Read issued last cycle; its data is on rd_data this cycle.
  logic                  infl_q, infl_last_q;

  logic                  head_valid_q, head_valid_d;
  logic                  head_last_q, head_last_d;
  logic [PORT_WIDTH-1:0] head_data_q, head_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic                  skid_last_q, skid_last_d;
  logic [PORT_WIDTH-1:0] skid_data_q, skid_data_d;

  logic                  pop;
  logic                  push;
  logic                  rd_en;
  logic                  issue_last;
  logic [1:0]            occ;
  logic [2:0]            level;

  // Occupancy plus in-flight minus pop must stay below 2 for a new read to fit.
  always_comb begin
    pop        = head_valid_q & bus.m_ready;
    push       = infl_q;
    occ        = {1'b0, head_valid_q} + {1'b0, skid_valid_q};
    level      = {1'b0, occ} + {2'b0, infl_q};
    issue_last = (rem_q == (ADDR_WIDTH+1)'(1));
    rd_en      = (state_q == StRead) && (rem_q != '0) && (level < (3'd2 + {2'b0, pop}));
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StRead;
            rem_d   = len;
            addr_d  = '0;
          end
        end
      end
      StRead: begin
        if (rd_en) begin
          rem_d = rem_q - (ADDR_WIDTH+1)'(1);
          // Hold the final address so a full-depth packet never wraps to 0.
          if (issue_last) begin
            state_d = StDrain;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      StDrain: begin
        if (pop && head_last_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    head_valid_d = head_valid_q;
    head_last_d  = head_last_q;
    head_data_d  = head_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    skid_data_d  = skid_data_q;
    if (pop) begin
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_last_d  = skid_last_q;
        head_data_d  = skid_data_q;
        skid_valid_d = push;
        skid_last_d  = push & infl_last_q;
        if (push) begin
          skid_data_d = bus.rd_data;
        end
      end else begin
        head_valid_d = push;
        head_last_d  = push & infl_last_q;
        if (push) begin
          head_data_d = bus.rd_data;
        end
      end
    end else if (push) begin
      if (!head_valid_q) begin
        head_valid_d = 1'b1;
        head_last_d  = infl_last_q;
        head_data_d  = bus.rd_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_last_d  = infl_last_q;
        skid_data_d  = bus.rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rem_q        <= '0;
      addr_q       <= '0;
      done_q       <= 1'b0;
      infl_q       <= 1'b0;
      infl_last_q  <= 1'b0;
      head_valid_q <= 1'b0;
      head_last_q  <= 1'b0;
      head_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      addr_q       <= addr_d;
      done_q       <= done_d;
      infl_q       <= rd_en;
      infl_last_q  <= rd_en & issue_last;
      head_valid_q <= head_valid_d;
      head_last_q  <= head_last_d;
      head_data_q  <= head_data_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      skid_data_q  <= skid_data_d;
    end
  end

  always_comb begin
    busy        = (state_q != StIdle);
    done        = done_q;
    bus.rd_en   = rd_en;
    bus.rd_addr = addr_q;
    bus.m_data  = head_data_q;
    bus.m_valid = head_valid_q;
    bus.m_last  = head_last_q;
  end

endmodule

// File: tb/tb_packet_reader.sv
// Directed bench for packet_reader: per-cycle vector table for the basic, zero-length and
// stalled packets, plus hand sequences for full-depth, mid-packet reset and ignored start.
module tb_packet_reader;

  localparam int unsigned AW = 10;
  localparam int unsigned PW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          busy;
  logic          done;

  packet_reader_if #(.ADDR_WIDTH(AW), .PORT_WIDTH(PW)) bus ();

  packet_reader #(.ADDR_WIDTH(AW), .PORT_WIDTH(PW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: mem[i] = 0x100 + i, data one cycle after rd_en.
  initial bus.rd_data = '0;
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= 32'h100 + 32'(bus.rd_addr);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic [AW:0] ln, input logic rdy, input logic r);
    @(negedge clk);
    start       = st;
    len         = ln;
    bus.m_ready = rdy;
    rst         = r;
    #1;
  endtask

  // Scoreboard for the hand-written sequences
  int           sb_len, sb_beat, sb_rd, sb_done, sb_lasts, sb_err, sb_last_addr;
  logic         sb_stalled;
  logic [31:0]  sb_prev_data;
  logic         sb_prev_last;

  task automatic sb_clear(input int l);
    sb_len = l; sb_beat = 0; sb_rd = 0; sb_done = 0; sb_lasts = 0; sb_err = 0;
    sb_last_addr = -1; sb_stalled = 1'b0;
  endtask

  task automatic sb_sample();
    if (bus.rd_en) begin
      if (32'(bus.rd_addr) !== 32'(sb_rd)) sb_err++;
      sb_last_addr = int'(bus.rd_addr);
      sb_rd++;
    end
    if (sb_stalled && (!bus.m_valid || bus.m_data !== sb_prev_data ||
                       bus.m_last !== sb_prev_last)) sb_err++;
    if (bus.m_valid && bus.m_ready) begin
      if (bus.m_data !== 32'h100 + 32'(sb_beat)) sb_err++;
      if (bus.m_last !== (sb_beat == sb_len - 1)) sb_err++;
      if (bus.m_last) sb_lasts++;
      sb_beat++;
    end
    if (sb_rd - sb_beat > 2) sb_err++;
    if (done) sb_done++;
    sb_stalled   = bus.m_valid && !bus.m_ready;
    sb_prev_data = bus.m_data;
    sb_prev_last = bus.m_last;
  endtask

  typedef struct {
    logic          st;
    logic [AW:0]   ln;
    logic          rdy;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic          mv;
    logic [31:0]   md;
    logic          ml;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  initial begin
    // len=4 at full rate, then len=0 started in the done cycle, then len=3 stalled 9 cycles
    vecs[0]  = '{1'b1, 11'd4, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0,   1'b0};
    vecs[1]  = '{1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd0, 1'b0, 32'h0,   1'b0};
    vecs[2]  = '{1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd1, 1'b0, 32'h0,   1'b0};
    vecs[3]  = '{1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd2, 1'b1, 32'h100, 1'b0};
    vecs[4]  = '{1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd3, 1'b1, 32'h101, 1'b0};
    vecs[5]  = '{1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 32'h102, 1'b0};
    vecs[6]  = '{1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 32'h103, 1'b1};
    vecs[7]  = '{1'b1, 11'd0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 32'h0,   1'b0};
    vecs[8]  = '{1'b0, 11'd0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 32'h0,   1'b0};
    vecs[9]  = '{1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0,   1'b0};
    vecs[10] = '{1'b1, 11'd3, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0,   1'b0};
    vecs[11] = '{1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd0, 1'b0, 32'h0,   1'b0};
    vecs[12] = '{1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd1, 1'b0, 32'h0,   1'b0};
    for (int i = 13; i <= 18; i++)
      vecs[i] = '{1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 32'h100, 1'b0};
    vecs[19] = '{1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd2, 1'b1, 32'h100, 1'b0};
    vecs[20] = '{1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 32'h101, 1'b0};
    vecs[21] = '{1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 32'h102, 1'b1};
    vecs[22] = '{1'b0, 11'd0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 32'h0,   1'b0};
    vecs[23] = '{1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0,   1'b0};

    bus.m_ready = 1'b0;

    // Reset state, start held high to confirm reset wins
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 11'd4, 1'b0, 1'b1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset rd_en", bus.rd_en, 0);
    check("reset rd_addr", bus.rd_addr, 0);
    check("reset m_valid", bus.m_valid, 0);
    check("reset m_last", bus.m_last, 0);
    check("reset m_data", bus.m_data, 0);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].st, vecs[i].ln, vecs[i].rdy, 1'b0);
      check($sformatf("vec%0d busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d done", i), done, vecs[i].done);
      check($sformatf("vec%0d rd_en", i), bus.rd_en, vecs[i].rd_en);
      if (vecs[i].rd_en) check($sformatf("vec%0d rd_addr", i), bus.rd_addr, vecs[i].addr);
      check($sformatf("vec%0d m_valid", i), bus.m_valid, vecs[i].mv);
      if (vecs[i].mv) begin
        check($sformatf("vec%0d m_data", i), bus.m_data, vecs[i].md);
        check($sformatf("vec%0d m_last", i), bus.m_last, vecs[i].ml);
      end
    end

    // Full-depth packet with m_ready toggling every cycle
    sb_clear(1024);
    step(1'b1, 11'd1024, 1'b0, 1'b0);
    sb_sample();
    for (int c = 1; c < 6000 && sb_done == 0; c++) begin
      step(1'b0, '0, c[0], 1'b0);
      sb_sample();
    end
    for (int c = 0; c < 4; c++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      sb_sample();
    end
    check("full beats", sb_beat, 1024);
    check("full reads", sb_rd, 1024);
    check("full last addr", sb_last_addr, 1023);
    check("full m_last count", sb_lasts, 1);
    check("full done count", sb_done, 1);
    check("full errors", sb_err, 0);

    // Reset during beat 2 of a len=8 packet
    sb_clear(8);
    step(1'b1, 11'd8, 1'b1, 1'b0);
    sb_sample();
    for (int c = 0; c < 4; c++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      sb_sample();
    end
    step(1'b0, '0, 1'b1, 1'b1);
    check("rst beat2 m_data", bus.m_data, 32'h102);
    step(1'b0, '0, 1'b1, 1'b0);
    check("post-rst m_valid", bus.m_valid, 0);
    check("post-rst busy", busy, 0);
    sb_clear(8);
    sb_sample();
    for (int c = 0; c < 6; c++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      sb_sample();
    end
    check("post-rst done count", sb_done, 0);
    check("post-rst beats", sb_beat, 0);
    sb_clear(2);
    step(1'b1, 11'd2, 1'b1, 1'b0);
    sb_sample();
    for (int c = 0; c < 12; c++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      sb_sample();
    end
    check("after-rst beats", sb_beat, 2);
    check("after-rst m_last count", sb_lasts, 1);
    check("after-rst done count", sb_done, 1);
    check("after-rst errors", sb_err, 0);

    // Start with len=5 while reading a len=4 packet is ignored
    sb_clear(4);
    step(1'b1, 11'd4, 1'b1, 1'b0);
    sb_sample();
    step(1'b0, '0, 1'b1, 1'b0);
    sb_sample();
    step(1'b1, 11'd5, 1'b1, 1'b0);
    sb_sample();
    for (int c = 0; c < 14; c++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      sb_sample();
    end
    check("ignore beats", sb_beat, 4);
    check("ignore reads", sb_rd, 4);
    check("ignore done count", sb_done, 1);
    check("ignore errors", sb_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
